// File: rtl/serial_divider.sv
// serial_divider: iterative restoring divider, one quotient bit per clock.
// Define SERIAL_DIVIDER_SIGNED_EN for two's complement operands (truncating division).
module serial_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] part, shq, dvs, part_nx, shq_nx, a_in, b_in, q_fin, r_fin;
  logic [WIDTH:0] sh;
  logic accept, zero, last, ge;
`ifdef SERIAL_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  always_comb begin
    a_in = dividend[WIDTH-1] ? -dividend : dividend;
    b_in = divisor[WIDTH-1] ? -divisor : divisor;
    q_fin = neg_q ? -shq_nx : shq_nx;
    r_fin = neg_r ? -part_nx : part_nx;
  end
  always_ff @(posedge clk)
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
`else
  always_comb begin
    a_in = dividend;
    b_in = divisor;
    q_fin = shq_nx;
    r_fin = part_nx;
  end
`endif
  // Shifted partial remainder needs one extra bit; a fitting trial is always below the divisor.
  always_comb begin
    accept = state == IDLE && start;
    zero = divisor == '0;
    last = cnt == CW'(WIDTH - 1);
    sh = {part, shq[WIDTH-1]};
    ge = sh >= {1'b0, dvs};
    part_nx = ge ? WIDTH'(sh - {1'b0, dvs}) : sh[WIDTH-1:0];
    shq_nx = {shq[WIDTH-2:0], ge};
    state_nx = state;
    state_nx = state == IDLE ? (start ? (zero ? DONE : RUN) : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      part <= '0;
      shq <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && zero) begin
      quotient <= '1;
      remainder <= dividend;
      div_by_zero <= 1'b1;
    end else if (accept) begin
      part <= '0;
      shq <= a_in;
      dvs <= b_in;
      cnt <= '0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      part <= part_nx;
      shq <= shq_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        quotient <= q_fin;
        remainder <= r_fin;
      end
    end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: doc/serial_divider.md
# serial_divider

Multi-cycle 8-bit restoring divider: the inverse of the datapath's ripple-carry adder. It computes quotient and remainder by one shift-and-subtract step per clock. It sits beside the ALU as a shared, iterative unit. The control path launches a division with a one-cycle `start` and waits for a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width; also the number of iteration cycles.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request pulse; accepted only in IDLE.
- `dividend` input WIDTH: numerator; sampled on the accepting edge only.
- `divisor` input WIDTH: denominator; sampled on the accepting edge only.
- `busy` output 1: high while iterating (RUN).
- `done` output 1: high for exactly one cycle when results become valid.
- `quotient` output WIDTH: result quotient; holds until the next accepted `start`.
- `remainder` output WIDTH: result remainder; holds likewise.
- `div_by_zero` output 1: qualifies the current results; holds likewise.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: `start`=1 and `divisor`≠0.
  - Load the working register {partial remainder = 0, shift = `dividend`}.
  - Latch `divisor`.
  - Clear the step counter and `div_by_zero`.
- IDLE → DONE: `start`=1 and `divisor`=0.
  - `quotient` = all ones, `remainder` = `dividend`, `div_by_zero` = 1.
- RUN step, once per cycle:
  - Shift {partial, shift} left by 1.
  - Form a (WIDTH+1)-bit trial = partial − divisor.
  - Trial non-negative (no borrow): partial = trial and the shifted-in quotient bit = 1.
  - Borrow: partial is kept (restored) and the quotient bit = 0.
  - Counter increments.
- RUN → DONE: after the step with counter = WIDTH−1.
  - `quotient` = shift register, `remainder` = partial.
- DONE → IDLE: unconditionally on the next edge.
- `start` while in RUN or DONE is ignored. It is not queued.
- The subtraction is internal (WIDTH+1 bits), so divisors ≥ 2^(WIDTH−1) never overflow.
- `quotient`/`remainder`/`div_by_zero` change only on entry to DONE, or on reset.

## Timing
- Reset (`rst`=1 at an edge): state = IDLE, counter = 0, and all outputs = 0 (`busy`, `done`, `quotient`, `remainder`, `div_by_zero`). `rst` has priority over `start`.
- Start accepted at edge E:
  - `busy`=1 after E through edge E+WIDTH.
  - `done`=1 for the single cycle after edge E+WIDTH, with results valid in that same cycle.
- Divide by zero: `done`=1 in the cycle after E. `busy` stays 0.
- Back-to-back: earliest next acceptance is the edge that returns DONE → IDLE plus one, i.e. E+WIDTH+2.
- Reset mid-RUN aborts the division. Outputs return to 0 on that edge, and no `done` is produced.
- `busy` and `done` are never high together.

## Configuration
- `SERIAL_DIVIDER_SIGNED_EN` defined: operands are two's complement.
  - At acceptance, absolute values are loaded and the result signs are recorded.
  - In the final step, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend (truncation toward zero).
  - Latency is unchanged.
  - Most-negative ÷ −1 yields `quotient` = 0x80, `remainder` = 0 (wraps; no flag).
  - Divide by zero behaves as in unsigned mode.
- Not defined: operands and results are unsigned. No sign logic is present.

## Test plan
- Basic unsigned: `dividend`=100, `divisor`=7, `start` pulse at edge E → `done` after E+8, `quotient`=14, `remainder`=2, `div_by_zero`=0. `busy` is high for exactly 8 cycles.
- Extremes: 255/1 → q=255, r=0. 3/10 → q=0, r=3. 255/255 → q=1, r=0. 200/128 → q=1, r=72.
- Divide by zero: 5/0 → `done` in the cycle after acceptance, q=0xFF, r=5, `div_by_zero`=1, `busy` never asserted. A following 9/3 → q=3, r=0, flag cleared.
- Handshake: a `start` with 50/5 held high across RUN and DONE → only the first is accepted. Exactly one `done` per acceptance. Outputs stay stable at q=10, r=0 until the next acceptance.
- Reset mid-operation: `rst` for 1 cycle at E+4 of 100/7 → all outputs 0, state IDLE, no `done`. A subsequent 100/7 completes correctly (14, 2).
- Signed (`SERIAL_DIVIDER_SIGNED_EN`): −7/2 → q=0xFD (−3), r=0xFF (−1). 7/−2 → q=0xFD, r=1. −128/−1 → q=0x80, r=0.
